adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 17 +
 rtl/ripple_adder64.sv | 26 ++
 rtl/rr_arbiter.sv | 21 ++
 rtl/adder_arbiter.sv | 159 +++++++++++++++
 tb/tb_adder_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the arbitrated 64-bit adder.
// Holds the FSM state encoding, the datapath width and the id-width helper.
package adder_arb_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_adder64.sv
// Plain 64-bit ripple-carry adder, the shared datapath.
// Combinational; the caller allows enough cycles for the carry chain to settle.
// No handshake: outputs follow inputs.
module ripple_adder64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_cin,
    output logic [63:0] o_sum,
    output logic        o_cout
);

    logic [64:0] w_c;

    assign w_c[0] = i_cin;

    genvar g;
    generate
        for (g = 0; g < 64; g++) begin : g_fa
            assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_c[64];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after i_ptr.
// Combinational, zero latency; grant is zero when no request is present.
// No backpressure of its own; the caller decides when a grant is consumed.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_pe;

    // Rotate so the pointer sits at bit 0, pick the lowest set bit, rotate back.
    assign w_rot = N'({i_req, i_req} >> i_ptr);
    assign w_pe  = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});
    assign o_gnt = N'(({w_pe, w_pe} << i_ptr) >> N);

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 64-bit ripple adder among NUM_REQ requesters (round-robin); ADDER_ARBITER_OVF_EN adds rsp_ovf.
// Latency: response valid SETTLE_CYCLES edges after the accept edge; accepts spaced SETTLE_CYCLES+2 apart.
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_in1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_in2,
    input  logic [NUM_REQ-1:0]          req_cin,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [id_w(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_W-1:0]           rsp_sum,
    output logic                        rsp_cout,
`ifdef ADDER_ARBITER_OVF_EN
    output logic                        rsp_ovf,
`endif
    output logic                        busy
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_cin;
    logic [ID_W-1:0]     r_id;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_sum;
    logic                r_rsp_cout;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic                w_accept;
    logic [DATA_W-1:0]   w_sum;
    logic                w_cout;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_rr_arbiter (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    ripple_adder64 u_adder (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_cin  (r_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_gnt_idx = ID_W'(i);
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

    // rst_n gates the combinational grant so it drops the instant reset asserts.
    assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_gnt : '0;
    assign w_accept  = |req_ready;

`ifdef ADDER_ARBITER_OVF_EN
    logic r_rsp_ovf;
    logic w_ovf;

    assign w_ovf   = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
    assign rsp_ovf = r_rsp_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_ovf <= 1'b0;
        end else if (r_state == ST_SETTLE && r_cnt == '0) begin
            r_rsp_ovf <= w_ovf;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_in1[int'(w_gnt_idx)*DATA_W +: DATA_W];
                        r_b     <= req_in2[int'(w_gnt_idx)*DATA_W +: DATA_W];
                        r_cin   <= req_cin[w_gnt_idx];
                        r_id    <= w_gnt_idx;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Operands were registered on the accept edge; SETTLE_CYCLES cycles later the carry is valid.
                    if (r_cnt == '0) begin
                        r_rsp_sum   <= w_sum;
                        r_rsp_cout  <= w_cout;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign busy      = r_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single operations, stall, reset mid-settle, round-robin fairness.
module tb_adder_arbiter;

    localparam int NR = 4;
    localparam int SC = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*64-1:0]   req_in1;
    logic [NR*64-1:0]   req_in2;
    logic [NR-1:0]      req_cin;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [63:0]        rsp_sum;
    logic               rsp_cout;
`ifdef ADDER_ARBITER_OVF_EN
    logic               rsp_ovf;
`endif
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_arbiter #(
        .NUM_REQ       (NR),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef ADDER_ARBITER_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One request from requester id; edges counted from and including the accept edge.
    task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic c,
                          input logic [63:0] exp_sum, input logic exp_c, input logic exp_ovf,
                          input int stall);
        int edges;
        @(negedge clk);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_in1[id*64 +: 64] = a;
        req_in2[id*64 +: 64] = b;
        req_cin[id] = c;
        rsp_ready = 1'b0;
        #1;
        check_eq("grant", req_ready, 4'b0001 << id);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        check_eq("busy_settle", busy, 1'b1);
        check_eq("ready_settle", req_ready, 4'b0000);
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check_eq("latency", edges, SC + 1);
        check_eq("sum", rsp_sum, exp_sum);
        check_eq("cout", rsp_cout, exp_c);
        check_eq("id", rsp_id, id);
`ifdef ADDER_ARBITER_OVF_EN
        check_eq("ovf", rsp_ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("unexpected ovf argument");
`endif
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_eq("stall_valid", rsp_valid, 1'b1);
            check_eq("stall_sum", rsp_sum, exp_sum);
            check_eq("stall_cout", rsp_cout, exp_c);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_done", rsp_valid, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcnt;
        int cyc;
        int gid [5];
        int gcyc[5];
        logic seen;
        logic [63:0] neg_a;

        rst_n     = 1'b0;
        req_valid = '1;
        req_in1   = '0;
        req_in2   = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        #1;
        check_eq("rst_ready", req_ready, 4'b0000);
        check_eq("rst_valid", rsp_valid, 1'b0);
        check_eq("rst_sum", rsp_sum, 64'd0);
        check_eq("rst_id", rsp_id, 2'd0);
        check_eq("rst_cout", rsp_cout, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
`ifdef ADDER_ARBITER_OVF_EN
        check_eq("rst_ovf", rsp_ovf, 1'b0);
`endif
        repeat (3) @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;

        neg_a = 64'd0 - 64'd12345678912345;
        run_op(0, 64'd12345678912345, 64'd98765432198765, 1'b0, 64'd111111111111110, 1'b0, 1'b0, 0);
        run_op(2, 64'd12345678912345, 64'd98765432198765, 1'b1, 64'd111111111111111, 1'b0, 1'b0, 0);
        run_op(1, neg_a, 64'd98765432198765, 1'b0, 64'd86419753286420, 1'b1, 1'b0, 0);
        run_op(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 10);
        run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);

        // Reset while requester 1 is in SETTLE; pointer is 2 at that point.
        @(negedge clk);
        req_valid = 4'b0010;
        req_in1[64 +: 64] = 64'd5;
        req_in2[64 +: 64] = 64'd6;
        @(negedge clk);
        req_valid = '1;
        @(negedge clk);
        check_eq("busy_pre_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_valid", rsp_valid, 1'b0);
        check_eq("arst_sum", rsp_sum, 64'd0);
        check_eq("arst_ready", req_ready, 4'b0000);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2 * SC + 4; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("no_rsp_after_rst", seen, 1'b0);

        // All requesters valid, consumer always ready.
        for (int i = 0; i < NR; i++) begin
            req_in1[i*64 +: 64] = 64'(i + 1);
            req_in2[i*64 +: 64] = 64'(i + 1);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        check_eq("first_after_rst", req_ready, 4'b0001);
        gcnt = 0;
        cyc  = 0;
        while (gcnt < 5 && cyc < 200) begin
            if (req_ready != '0) begin
                gid[gcnt]  = oh2idx(req_ready);
                gcyc[gcnt] = cyc;
                gcnt++;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("rr_count", gcnt, 5);
        for (int k = 0; k < gcnt; k++) check_eq("rr_order", gid[k], k % NR);
        for (int k = 1; k < gcnt; k++) check_eq("rr_spacing", gcyc[k] - gcyc[k-1], SC + 2);
        req_valid = '0;
        repeat (SC + 4) @(negedge clk);
        check_eq("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
